stack_dump_tx: RTL and testbench

- Debug transmitter for the logic controller core: on request, snapshots the evaluation bit stack and shifts it off-chip as a framed, clocked serial stream.
- Gives silicon the stack visibility that simulation gets from probing the stack register hierarchically.
- Sits beside the executor; stack_in is tied to the executor's stack register, and the serial pins map onto uio outputs.
- An external receiver (logic analyser or MCU) samples sdata_out on the rising edge of sclk_out while sframe_out is high.

---
 rtl/stack_dump_tx.sv | 114 +++++++++++
 tb/tb_stack_dump_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_dump_tx.sv
// Debug transmitter: snapshots the executor's bit stack on request and shifts it
// out TOS-first as a framed serial stream (sframe/sclk/sdata), then holds a stop gap.
module stack_dump_tx #(
  parameter int WIDTH  = 16,
  parameter int CLKDIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] stack_in,
  input  logic             req,
  output logic             busy,
  output logic             done,
  output logic             sframe_out,
  output logic             sclk_out,
  output logic             sdata_out
);

  localparam int CW = $clog2(CLKDIV);
  localparam int BW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKDIV / 2);
  localparam logic [BW-1:0] IDX_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_idx;
  logic [WIDTH-1:0] shreg;

  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] shreg_nxt;

  always_comb begin
    cnt_nxt   = cnt + CW'(1);
    shreg_nxt = shreg >> 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sframe_out <= 1'b0;
      sclk_out   <= 1'b0;
      sdata_out  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state      <= SHIFT;
            shreg      <= stack_in;
            cnt        <= '0;
            bit_idx    <= '0;
            busy       <= 1'b1;
            sframe_out <= 1'b1;
            sclk_out   <= 1'b0;
            sdata_out  <= stack_in[0];
          end
        end

        SHIFT: begin
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            sclk_out <= 1'b0;
            if (bit_idx == IDX_LAST) begin
              state      <= STOP;
              sframe_out <= 1'b0;
              sdata_out  <= 1'b0;
            end else begin
              shreg     <= shreg_nxt;
              sdata_out <= shreg_nxt[0];
              bit_idx   <= bit_idx + BW'(1);
            end
          end else begin
            cnt      <= cnt_nxt;
            // sclk rises mid-bit so data has settled half a bit before the receiver samples
            sclk_out <= (cnt_nxt >= CNT_HALF);
          end
        end

        STOP: begin
          if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt_nxt;
          end
        end

        default: begin
          state      <= IDLE;
          cnt        <= '0;
          busy       <= 1'b0;
          sframe_out <= 1'b0;
          sclk_out   <= 1'b0;
          sdata_out  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_dump_tx.sv
// Bench for stack_dump_tx: a serial receiver model decodes each frame and compares it
// against a queue of expected stack words; a second instance covers WIDTH=1, CLKDIV=2.
module tb_stack_dump_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] stack_a = '0;
  logic        req_a = 1'b0;
  logic        a_busy, a_done, a_sframe, a_sclk, a_sdata;
  logic [0:0]  stack_b = '0;
  logic        req_b = 1'b0;
  logic        b_busy, b_done, b_sframe, b_sclk, b_sdata;

  stack_dump_tx #(.WIDTH(16), .CLKDIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .stack_in(stack_a), .req(req_a),
    .busy(a_busy), .done(a_done), .sframe_out(a_sframe),
    .sclk_out(a_sclk), .sdata_out(a_sdata)
  );

  stack_dump_tx #(.WIDTH(1), .CLKDIV(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .stack_in(stack_b), .req(req_b),
    .busy(b_busy), .done(b_done), .sframe_out(b_sframe),
    .sclk_out(b_sclk), .sdata_out(b_sdata)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] exp_q[$];

  // Receiver model state for dut_a
  int          cyc = 0, m_flen = 0, m_blen = 0, m_bits = 0;
  int          done_cnt = 0, frame_cnt = 0;
  int          last_rise = 0, prev_rise = 0, last_gap = 0, low_run = 0;
  logic [15:0] m_word = '0;
  logic        p_sframe = 1'b0, p_sclk = 1'b0, p_busy = 1'b0, p_done = 1'b0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      m_flen = 0; m_blen = 0; m_bits = 0; m_word = '0; low_run = 0;
      p_sframe = 1'b0; p_sclk = 1'b0; p_busy = 1'b0; p_done = 1'b0;
    end else begin
      if (a_sframe) begin
        m_flen++;
        if (!p_sclk && a_sclk) begin
          if (m_bits < 16) m_word[m_bits] = a_sdata;
          m_bits++;
        end
      end else begin
        chk("idle_lines", 32'({a_sclk, a_sdata}), 32'd0);
        low_run++;
      end
      if (!p_sframe && a_sframe) begin
        prev_rise = last_rise;
        last_rise = cyc;
        last_gap  = low_run;
        low_run   = 0;
      end
      if (p_sframe && !a_sframe) begin
        frame_cnt++;
        chk("frame_len", 32'(m_flen), 32'd64);
        chk("frame_bits", 32'(m_bits), 32'd16);
        if (exp_q.size() == 0) chk("exp_q_empty", 32'd1, 32'd0);
        else chk("word", 32'(m_word), 32'(exp_q.pop_front()));
        m_flen = 0; m_bits = 0; m_word = '0;
      end
      if (a_busy) m_blen++;
      if (p_busy && !a_busy) begin
        chk("busy_len", 32'(m_blen), 32'd68);
        chk("done_at_busy_fall", 32'(a_done), 32'd1);
        m_blen = 0;
      end
      if (a_done) begin
        done_cnt++;
        chk("done_width", 32'(p_done), 32'd0);
      end
      p_sframe = a_sframe; p_sclk = a_sclk; p_busy = a_busy; p_done = a_done;
    end
  end

  task automatic wait_done(input string tag, input int lim);
    logic got;
    got = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (a_done) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  task automatic start_dump(input logic [15:0] w);
    @(negedge clk);
    stack_a = w;
    req_a   = 1'b1;
    exp_q.push_back(w);
    @(negedge clk);
    chk("accept_busy", 32'(a_busy), 32'd1);
    req_a = 1'b0;
  endtask

  logic [4:0] b_exp [6] = '{5'b10101, 5'b10111, 5'b10000, 5'b10000, 5'b01000, 5'b00000};

  initial begin
    int d0, f0;
    #1 rst_n = 1'b0;
    // Reset held: outputs stay low whatever req does
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_a = ~req_a;
      chk("rst_out_a", 32'({a_busy, a_done, a_sframe, a_sclk, a_sdata}), 32'd0);
      chk("rst_out_b", 32'({b_busy, b_done, b_sframe, b_sclk, b_sdata}), 32'd0);
    end
    @(negedge clk);
    req_a = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_idle", 32'({a_busy, a_done, a_sframe, a_sclk, a_sdata}), 32'd0);

    // Basic dump
    d0 = done_cnt;
    start_dump(16'hA5C3);
    wait_done("done_basic", 200);
    repeat (2) @(negedge clk);
    chk("done_cnt_basic", 32'(done_cnt), 32'(d0 + 1));
    chk("post_basic_idle", 32'({a_busy, a_done, a_sframe}), 32'd0);

    // Snapshot and request while busy
    repeat (3) @(negedge clk);
    d0 = done_cnt; f0 = frame_cnt;
    start_dump(16'h00FF);
    repeat (18) @(negedge clk);
    stack_a = 16'hFF00;
    req_a   = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    wait_done("done_snap", 200);
    repeat (100) @(negedge clk);
    chk("snap_frames", 32'(frame_cnt), 32'(f0 + 1));
    chk("snap_dones", 32'(done_cnt), 32'(d0 + 1));

    // Back-to-back with req held
    begin
      int n;
      logic ok;
      n = 0; ok = 1'b0;
      @(negedge clk);
      stack_a = 16'h8001;
      req_a   = 1'b1;
      exp_q.push_back(16'h8001);
      exp_q.push_back(16'h8001);
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (a_done) begin
          n++;
          if (n == 2) begin
            req_a = 1'b0;
            ok = 1'b1;
            break;
          end
        end
      end
      chk("b2b_two_done", 32'(ok), 32'd1);
      repeat (3) @(negedge clk);
      chk("b2b_spacing", 32'(last_rise - prev_rise), 32'd69);
      chk("b2b_gap", 32'(last_gap), 32'd5);
      chk("b2b_q_drained", 32'(exp_q.size()), 32'd0);
    end

    // Reset in the middle of a frame
    repeat (5) @(negedge clk);
    d0 = done_cnt;
    @(negedge clk);
    stack_a = 16'h1234;
    req_a   = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    repeat (29) @(negedge clk);
    chk("midframe_active", 32'(a_sframe), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_out", 32'({a_busy, a_done, a_sframe, a_sclk, a_sdata}), 32'd0);
    repeat (3) @(negedge clk);
    chk("no_done_on_abort", 32'(done_cnt), 32'(d0));
    f0 = frame_cnt;
    stack_a = 16'hBEEF;
    req_a   = 1'b1;
    rst_n   = 1'b1;
    exp_q.push_back(16'hBEEF);
    wait_done("done_after_rst", 200);
    req_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("frame_after_rst", 32'(frame_cnt), 32'(f0 + 1));

    // WIDTH=1, CLKDIV=2 corner
    @(negedge clk);
    stack_b = 1'b1;
    req_b   = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req_b = 1'b0;
      chk($sformatf("w1_cyc%0d", k + 1),
          32'({b_busy, b_done, b_sframe, b_sclk, b_sdata}), 32'(b_exp[k]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout obs=%0d exp=0", checks);
    $fatal(1);
  end

endmodule
